// File: rtl/vnu_acc_pkg.sv
// vnu_acc_pkg: shared types and helpers for the serial variable-node accumulator.
//   state_t      : FSM state encoding (IDLE, ACC, SUM, EMIT)
//   max_mag()    : largest sign-magnitude magnitude for a w-bit message
//   is_neg_zero(): detects the one's-complement negative zero (all ones, no +1 correction)
package vnu_acc_pkg;

    typedef enum logic [1:0] {IDLE, ACC, SUM, EMIT} state_t;

    function automatic int max_mag(input int w);
        return (1 << (w - 1)) - 1;
    endfunction

    // data is zero-extended by the caller; only the low w bits are inspected
    function automatic logic is_neg_zero(input logic [31:0] data, input logic corr, input int w);
        logic [31:0] mask;
        mask = (32'd1 << w) - 32'd1;
        return (corr == 1'b0) && ((data & mask) == mask);
    endfunction

endpackage

// File: rtl/compl2sm.sv
// compl2sm: WA-bit two's complement -> W-bit sign-magnitude {sign, mag}.
//   i_val : WA-bit two's complement value
//   o_sm  : W-bit sign-magnitude result; zero always comes out as +0
// Build option VNU_ACC_SAT_EN: when defined the magnitude saturates at
// 2^(W-1)-1, otherwise the low W-1 bits of |i_val| are kept (truncation).
module compl2sm
    import vnu_acc_pkg::*;
#(
    parameter int W  = 6,
    parameter int WA = 9
) (
    input  logic [WA-1:0] i_val,
    output logic [W-1:0]  o_sm
);

    logic [WA-1:0] mag;
    logic [W-2:0]  mag_out;

    assign mag = i_val[WA-1] ? (~i_val + WA'(1)) : i_val;

`ifdef VNU_ACC_SAT_EN
    always_comb begin
        if (mag > WA'(max_mag(W)))
            mag_out = (W-1)'(max_mag(W));
        else
            mag_out = mag[W-2:0];
    end
`else
    // upper magnitude bits are intentionally dropped in the truncating build
    logic unused_hi;
    assign unused_hi = ^mag[WA-1:W-1];
    assign mag_out   = mag[W-2:0];
`endif

    // sign follows the value only; a negative value whose magnitude truncates
    // to zero keeps its sign bit
    assign o_sm = {i_val[WA-1], mag_out};

endmodule

// File: rtl/vnu_acc.sv
// vnu_acc: serial variable-node accumulator.
// Takes a channel LLR followed by DV check-to-variable messages (one's
// complement + separate +1 correction bit), sums them, then emits the DV
// extrinsic messages (total - own message) in arrival order as sign-magnitude.
//   i_clk, i_rst        : clock, asynchronous active-high reset
//   i_valid/o_ready     : input beat handshake, i_data + i_sign carry the value
//   o_valid/i_ready     : extrinsic beat handshake
//   o_data              : extrinsic message {sign, mag}
//   o_last              : marks the DV-th extrinsic beat
//   o_hard              : hard decision (total < 0), held for the whole output phase
// Build option VNU_ACC_SAT_EN selects saturation (else truncation) in compl2sm.
module vnu_acc
    import vnu_acc_pkg::*;
#(
    parameter int DV = 4,
    parameter int W  = 6
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_valid,
    output logic         o_ready,
    input  logic [W-1:0] i_data,
    input  logic         i_sign,
    output logic         o_valid,
    input  logic         i_ready,
    output logic [W-1:0] o_data,
    output logic         o_last,
    output logic         o_hard
);

    localparam int WA = W + $clog2(DV + 1);
    localparam int CW = (DV > 1) ? $clog2(DV) : 1;

    state_t               state, state_nxt;
    logic [CW-1:0]        count, sel;
    logic signed [WA-1:0] total, in_val, ext_val;
    logic [DV-1:0][W-1:0] msg_buf;
    logic [W-1:0]         sm;
    logic                 in_fire, out_fire, cnt_last;

    assign in_fire  = i_valid & o_ready;
    assign out_fire = o_valid & i_ready;
    assign cnt_last = (count == CW'(DV - 1));

    // input value: sext(data) + correction, negative zero forced to 0
    always_comb begin
        if (is_neg_zero(32'(i_data), i_sign, W))
            in_val = '0;
        else
            in_val = {{(WA-W){i_data[W-1]}}, i_data} + {{(WA-1){1'b0}}, i_sign};
    end

    // SUM loads extrinsic 0; EMIT preloads the one after the beat on display
    assign sel     = (state == EMIT) ? count + CW'(1) : '0;
    assign ext_val = total - {{(WA-W){msg_buf[sel][W-1]}}, msg_buf[sel]};

    compl2sm #(.W(W), .WA(WA)) u_c2sm (
        .i_val (ext_val),
        .o_sm  (sm)
    );

    // state register
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) state <= IDLE;
        else       state <= state_nxt;
    end

    // next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_fire)             state_nxt = ACC;
            ACC:     if (in_fire && cnt_last) state_nxt = SUM;
            SUM:                              state_nxt = EMIT;
            EMIT:    if (out_fire && cnt_last) state_nxt = IDLE;
            default:                          state_nxt = IDLE;
        endcase
    end

    // output logic: ready is low while reset is held
    always_comb begin
        o_ready = ((state == IDLE) || (state == ACC)) && !i_rst;
    end

    // datapath and registered outputs; count doubles as the emit index
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            total   <= '0;
            count   <= '0;
            msg_buf <= '0;
            o_valid <= 1'b0;
            o_last  <= 1'b0;
            o_hard  <= 1'b0;
            o_data  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_fire) begin
                        total <= in_val;
                        count <= '0;
                    end
                end
                ACC: begin
                    if (in_fire) begin
                        msg_buf[count] <= in_val[W-1:0];
                        total          <= total + in_val;
                        count          <= cnt_last ? '0 : count + CW'(1);
                    end
                end
                SUM: begin
                    o_hard  <= total[WA-1];
                    o_data  <= sm;
                    o_last  <= 1'b0;
                    o_valid <= 1'b1;
                end
                EMIT: begin
                    if (out_fire) begin
                        if (cnt_last) begin
                            o_valid <= 1'b0;
                            o_last  <= 1'b0;
                            count   <= '0;
                        end else begin
                            o_data <= sm;
                            o_last <= (sel == CW'(DV - 1));
                            count  <= sel;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_vnu_acc.sv
module tb_vnu_acc;

    localparam int DV = 4;
    localparam int W  = 6;

    logic         i_clk, i_rst, i_valid, o_ready, i_sign, o_valid, i_ready, o_last, o_hard;
    logic [W-1:0] i_data, o_data;

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic [DV:0][W-1:0]   d;
        logic [DV:0]          s;
        logic [DV-1:0][W-1:0] e;
        logic                 hard;
    } vec_t;

    vec_t tbl [3];

    vnu_acc #(.DV(DV), .W(W)) dut (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_valid (i_valid),
        .o_ready (o_ready),
        .i_data  (i_data),
        .i_sign  (i_sign),
        .o_valid (o_valid),
        .i_ready (i_ready),
        .o_data  (o_data),
        .o_last  (o_last),
        .o_hard  (o_hard)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic int val_of(input logic [W-1:0] d, input logic s);
        logic signed [W-1:0] sd;
        sd = d;
        if (d == {W{1'b1}} && !s) return 0;
        return int'(sd) + (s ? 1 : 0);
    endfunction

    function automatic logic [W-1:0] to_sm(input int e);
        int m;
        logic [31:0] mm;
        m = (e < 0) ? -e : e;
`ifdef VNU_ACC_SAT_EN
        if (m > (1 << (W-1)) - 1) m = (1 << (W-1)) - 1;
`else
        m = m % (1 << (W-1));
`endif
        mm = m;
        return {(e < 0), mm[W-2:0]};
    endfunction

    function automatic vec_t gen_random();
        vec_t v;
        int vals[DV+1];
        int tot;
        tot = 0;
        for (int b = 0; b <= DV; b++) begin
            do begin
                v.d[b] = W'($urandom_range(0, (1 << W) - 1));
                v.s[b] = 1'($urandom_range(0, 1));
            end while (v.d[b] == {1'b0, {(W-1){1'b1}}} && v.s[b]);
            vals[b] = val_of(v.d[b], v.s[b]);
            tot += vals[b];
        end
        for (int k = 0; k < DV; k++) v.e[k] = to_sm(tot - vals[k+1]);
        v.hard = (tot < 0);
        return v;
    endfunction

    // ---------------- drivers ----------------
    // called just after a negedge; returns just after the negedge following the transfer
    task automatic send_beat(input logic [W-1:0] d, input logic s);
        int n;
        n = 0;
        i_valid = 1'b1;
        i_data  = d;
        i_sign  = s;
        #1;
        while (!o_ready && n < 200) begin
            @(negedge i_clk);
            n++;
        end
        if (!o_ready) begin
            chk("send_timeout", 32'(o_ready), 32'd1);
            return;
        end
        @(posedge i_clk);
        @(negedge i_clk);
    endtask

    task automatic collect_node(input logic [DV-1:0][W-1:0] e, input logic hard,
                                input int stall_k, input int stall_n, input string tag);
        int n;
        for (int k = 0; k < DV; k++) begin
            n = 0;
            while (!o_valid && n < 50) begin
                @(negedge i_clk);
                n++;
            end
            if (!o_valid) begin
                chk({tag, "_out_timeout"}, 32'(o_valid), 32'd1);
                return;
            end
            if (k == 0) chk({tag, "_latency"}, 32'(n), 32'd1);
            if (k == stall_k) begin
                i_ready = 1'b0;
                for (int c = 0; c < stall_n; c++) begin
                    chk({tag, "_hold_data"}, 32'(o_data), 32'(e[k]));
                    chk({tag, "_hold_ready"}, 32'(o_ready), 32'd0);
                    chk({tag, "_hold_valid"}, 32'(o_valid), 32'd1);
                    @(negedge i_clk);
                end
                i_ready = 1'b1;
            end
            chk({tag, "_data"}, 32'(o_data), 32'(e[k]));
            chk({tag, "_last"}, 32'(o_last), 32'(k == DV - 1));
            chk({tag, "_hard"}, 32'(o_hard), 32'(hard));
            chk({tag, "_ready_low"}, 32'(o_ready), 32'd0);
            @(posedge i_clk);
            @(negedge i_clk);
        end
        chk({tag, "_idle_valid"}, 32'(o_valid), 32'd0);
    endtask

    task automatic run_node(input vec_t v, input int stall_k, input int stall_n, input string tag);
        for (int b = 0; b <= DV; b++) send_beat(v.d[b], v.s[b]);
        i_valid = 1'b0;
        collect_node(v.e, v.hard, stall_k, stall_n, tag);
    endtask

    initial begin
        // nominal: +5 | +3, -2, +7, -31  -> total -18
        tbl[0].d    = {6'b100000, 6'b000111, 6'b111101, 6'b000011, 6'b000101};
        tbl[0].s    = 5'b10100;
        tbl[0].e    = {6'b001101, 6'b111001, 6'b110000, 6'b110101};
        tbl[0].hard = 1'b1;
        // all +31 -> ext 124
        tbl[1].d    = {5{6'b011111}};
        tbl[1].s    = 5'b00000;
`ifdef VNU_ACC_SAT_EN
        tbl[1].e    = {4{6'b011111}};
`else
        tbl[1].e    = {4{6'b011100}};
`endif
        tbl[1].hard = 1'b0;
        // negative zero: +4 | -0, +1, +1, +1 -> total 7
        tbl[2].d    = {6'b000001, 6'b000001, 6'b000001, 6'b111111, 6'b000100};
        tbl[2].s    = 5'b00000;
        tbl[2].e    = {6'b000110, 6'b000110, 6'b000110, 6'b000111};
        tbl[2].hard = 1'b0;

        i_rst = 1'b1; i_valid = 1'b0; i_ready = 1'b1; i_data = '0; i_sign = 1'b0;
        repeat (2) @(negedge i_clk);
        chk("rst_valid", 32'(o_valid), 32'd0);
        chk("rst_last",  32'(o_last),  32'd0);
        chk("rst_hard",  32'(o_hard),  32'd0);
        chk("rst_data",  32'(o_data),  32'd0);
        chk("rst_ready", 32'(o_ready), 32'd0);
        i_rst = 1'b0;
        #1;
        chk("post_rst_ready", 32'(o_ready), 32'd1);
        @(negedge i_clk);

        // table-driven vectors
        for (int t = 0; t < 3; t++) run_node(tbl[t], -1, 0, $sformatf("tbl%0d", t));

        // backpressure at the 2nd extrinsic beat
        run_node(tbl[0], 1, 3, "bp");

        // reset in the middle of ACC, then a clean nominal node
        for (int b = 0; b < 3; b++) send_beat(tbl[0].d[b], tbl[0].s[b]);
        i_valid = 1'b0;
        i_rst = 1'b1;
        #1;
        chk("midrst_valid", 32'(o_valid), 32'd0);
        chk("midrst_ready", 32'(o_ready), 32'd0);
        @(negedge i_clk);
        i_rst = 1'b0;
        #1;
        chk("midrst_release_ready", 32'(o_ready), 32'd1);
        @(negedge i_clk);
        run_node(tbl[0], -1, 0, "after_rst");

        // back-to-back: i_valid held high while node A emits
        for (int b = 0; b <= DV; b++) send_beat(tbl[0].d[b], tbl[0].s[b]);
        i_valid = 1'b1;
        i_data  = tbl[2].d[0];
        i_sign  = tbl[2].s[0];
        collect_node(tbl[0].e, tbl[0].hard, -1, 0, "b2b_a");
        chk("b2b_ready_after_last", 32'(o_ready), 32'd1);
        run_node(tbl[2], -1, 0, "b2b_b");

        // randomized nodes against the model
        for (int r = 0; r < 30; r++) begin
            vec_t v;
            v = gen_random();
            run_node(v, $urandom_range(0, DV), $urandom_range(1, 3), $sformatf("rnd%0d", r));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule
